// File: rtl/div_nonrestoring_sgn.sv
// Sequential non-restoring divider, one quotient bit per clock, unsigned or
// truncating signed mode, with a correction stage and divide-by-zero/overflow flags.
module div_nonrestoring_sgn #(
  parameter int WA = 32,
  parameter int WB = 16,
  parameter int CW = $clog2(WA+1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          sign,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic [WA-1:0] q,
  output logic [WB-1:0] r,
  output logic          busy,
  output logic          ready,
  output logic          dz,
  output logic          ovf,
  output logic [CW-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CW-1:0] LAST = CW'(WA-1);

  state_t        state;
  logic [WA-1:0] qreg;
  logic [WB:0]   pr;
  logic [WB-1:0] b_mag_r;
  logic          sq, sr, sgn_r;

  logic [WA-1:0] a_mag;
  logic [WB-1:0] b_mag;
  logic [WB+1:0] t, sum;
  logic [WB-1:0] rm;

  // Operand magnitudes, one iteration step and the final remainder correction.
  // The partial remainder is WB+1 bits wide so a divisor with its MSB set
  // still divides correctly in unsigned mode.
  always_comb begin
    a_mag = (sign && a[WA-1]) ? -a : a;
    b_mag = (sign && b[WB-1]) ? -b : b;
    t     = {pr, qreg[WA-1]};
    sum   = pr[WB] ? t + {2'b00, b_mag_r} : t - {2'b00, b_mag_r};
    rm    = pr[WB] ? pr[WB-1:0] + b_mag_r : pr[WB-1:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      busy    <= 1'b0;
      ready   <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      q       <= '0;
      r       <= '0;
      count   <= '0;
      qreg    <= '0;
      pr      <= '0;
      b_mag_r <= '0;
      sq      <= 1'b0;
      sr      <= 1'b0;
      sgn_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
            count <= '0;
            // A zero divisor completes on the accepting edge without running.
            if (b == '0) begin
              ready <= 1'b1;
              dz    <= 1'b1;
              q     <= '1;
              r     <= a[WB-1:0];
            end else begin
              busy    <= 1'b1;
              state   <= RUN;
              qreg    <= a_mag;
              b_mag_r <= b_mag;
              pr      <= '0;
              sq      <= sign & (a[WA-1] ^ b[WB-1]);
              sr      <= sign & a[WA-1];
              sgn_r   <= sign;
            end
          end
        end
        RUN: begin
          pr    <= sum[WB:0];
          qreg  <= {qreg[WA-2:0], ~sum[WB+1]};
          count <= count + 1'b1;
          if (count == LAST)
            state <= FIX;
        end
        FIX: begin
          q     <= sq ? -qreg : qreg;
          r     <= sr ? -rm : rm;
          // Only min / -1 produces a positive magnitude of 2^(WA-1).
          ovf   <= sgn_r & ~sq & qreg[WA-1];
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nonrestoring_sgn.sv
// Directed bench for div_nonrestoring_sgn with hand-computed expected results.
module tb_div_nonrestoring_sgn;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [15:0] b;
  logic [31:0] q;
  logic [15:0] r;
  logic        busy, ready, dz, ovf;
  logic [5:0]  count;

  int nCompared = 0;
  int nFailed   = 0;

  div_nonrestoring_sgn #(.WA(32), .WB(16)) dut (
    .clk(clk), .clr(clr), .start(start), .sign(sign), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .ready(ready), .dz(dz), .ovf(ovf), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation for a single accepting edge, then drops start.
  task automatic applyStimulus(input logic [31:0] aIn, input logic [15:0] bIn, input logic signIn);
    a     = aIn;
    b     = bIn;
    sign  = signIn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] aIn, input logic [15:0] bIn,
                       input logic signIn, input logic [31:0] expQ, input logic [15:0] expR,
                       input logic expOvf);
    int n;
    applyStimulus(aIn, bIn, signIn);
    checkOutput({tag, " busy after start"}, 64'(busy), 64'd1);
    checkOutput({tag, " dz after start"}, 64'(dz), 64'd0);
    checkOutput({tag, " count after start"}, 64'(count), 64'd0);
    waitDone(n);
    checkOutput({tag, " busy cycles"}, 64'(n), 64'd33);
    checkOutput({tag, " ready"}, 64'(ready), 64'd1);
    checkOutput({tag, " q"}, 64'(q), 64'(expQ));
    checkOutput({tag, " r"}, 64'(r), 64'(expR));
    checkOutput({tag, " dz"}, 64'(dz), 64'd0);
    checkOutput({tag, " ovf"}, 64'(ovf), 64'(expOvf));
    checkOutput({tag, " count done"}, 64'(count), 64'd32);
  endtask

  task automatic runDivZero(input string tag, input logic signIn);
    applyStimulus(32'h0000_1234, 16'h0000, signIn);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " ready"}, 64'(ready), 64'd1);
    checkOutput({tag, " dz"}, 64'(dz), 64'd1);
    checkOutput({tag, " q"}, 64'(q), 64'hFFFF_FFFF);
    checkOutput({tag, " r"}, 64'(r), 64'h1234);
    @(posedge clk); #1;
    checkOutput({tag, " busy later"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    clr   = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset ready", 64'(ready), 64'd0);
    checkOutput("reset q", 64'(q), 64'd0);
    checkOutput("reset count", 64'(count), 64'd0);
    clr = 1'b0;
    @(posedge clk); #1;

    runOp("u100/7", 32'd100, 16'd7, 1'b0, 32'd14, 16'd2, 1'b0);
    runOp("s-100/7", 32'hFFFF_FF9C, 16'd7, 1'b1, 32'hFFFF_FFF2, 16'hFFFE, 1'b0);
    runOp("s100/-7", 32'd100, 16'hFFF9, 1'b1, 32'hFFFF_FFF2, 16'd2, 1'b0);
    runOp("s-100/-7", 32'hFFFF_FF9C, 16'hFFF9, 1'b1, 32'd14, 16'hFFFE, 1'b0);
    runOp("wideFE", 32'hFFFF_FFFE, 16'hFFFF, 1'b0, 32'h0001_0000, 16'hFFFE, 1'b0);
    runOp("wideFF", 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 32'h0001_0001, 16'h0000, 1'b0);

    runDivZero("dz unsigned", 1'b0);
    runDivZero("dz signed", 1'b1);
    runOp("after dz", 32'd100, 16'd7, 1'b0, 32'd14, 16'd2, 1'b0);

    runOp("ovf", 32'h8000_0000, 16'hFFFF, 1'b1, 32'h8000_0000, 16'h0000, 1'b1);

    // A start pulse with new operands while busy must be ignored.
    applyStimulus(32'd1000, 16'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(32'd5, 16'd1, 1'b0);
    waitDone(n);
    checkOutput("ignore busy cycles", 64'(n), 64'd27);
    checkOutput("ignore q", 64'(q), 64'd333);
    checkOutput("ignore r", 64'(r), 64'd1);
    @(posedge clk); #1;
    checkOutput("ignore stays idle", 64'(busy), 64'd0);

    // Reset in the middle of an operation abandons it.
    applyStimulus(32'd100, 16'd7, 1'b0);
    n = 0;
    while (count != 6'd10 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("clr reached count10", 64'(count), 64'd10);
    clr = 1'b1;
    #1;
    checkOutput("clr busy", 64'(busy), 64'd0);
    checkOutput("clr ready", 64'(ready), 64'd0);
    checkOutput("clr q", 64'(q), 64'd0);
    checkOutput("clr r", 64'(r), 64'd0);
    checkOutput("clr count", 64'(count), 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    // start held high across ready launches the next operation immediately.
    a = 32'd100; b = 16'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd1000; b = 16'd3;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput("b2b first ready", 64'(ready), 64'd1);
    checkOutput("b2b first q", 64'(q), 64'd14);
    checkOutput("b2b first r", 64'(r), 64'd2);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b ready cleared", 64'(ready), 64'd0);
    checkOutput("b2b busy", 64'(busy), 64'd1);
    checkOutput("b2b count", 64'(count), 64'd0);
    waitDone(n);
    checkOutput("b2b second cycles", 64'(n), 64'd33);
    checkOutput("b2b second q", 64'(q), 64'd333);
    checkOutput("b2b second r", 64'(r), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
